// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: central sequencer for the 5-stage pipeline.
// Each cycle it issues one flow code (WORK / STOP / REFRESH) to the PC
// register and to the IF/ID, ID/EX and EX/MEM pipeline registers. It also
// drives the PC redirect request. Four events are arbitrated:
// branch/jump redirect, divide stall, interrupt entry and load-use hazard.
//
// Ports:
//   clk, rst                       core clock, async active-high reset
//   ex_jump_i / ex_jump_addr_i     taken branch/jump resolved in EX, target
//   ex_mem_rd_i / ex_rd_adder_i    EX holds a load, its destination register
//   id_rs{1,2}_adder_i / _use_i    ID source register indices and use flags
//   div_start_i / div_done_i       divide issue pulse, divider result valid
//   int_req_i / int_addr_i         level interrupt request, trap vector
//   flow_*_o                       per-register flow codes
//   pc_jump_en_o / pc_jump_addr_o  PC redirect request and target
//   int_ack_o                      interrupt taken (1-cycle pulse)
//   div_err_o                      divide timeout (1-cycle pulse)
module pipe_flow_ctrl #(
   parameter int unsigned               FLOW_WIDTH     = 2,
   parameter logic [FLOW_WIDTH-1:0]     FLOW_WORK      = 2'b00,
   parameter logic [FLOW_WIDTH-1:0]     FLOW_STOP      = 2'b01,
   parameter logic [FLOW_WIDTH-1:0]     FLOW_REFRESH   = 2'b10,
   parameter int unsigned               CPU_WIDTH      = 32,
   parameter int unsigned               REG_ADDR_WIDTH = 5,
   parameter int unsigned               DIV_TIMEOUT    = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ex_jump_i,
   input  logic [CPU_WIDTH-1:0]      ex_jump_addr_i,
   input  logic                      ex_mem_rd_i,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_adder_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_adder_i,
   input  logic                      id_rs1_use_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_adder_i,
   input  logic                      id_rs2_use_i,
   input  logic                      div_start_i,
   input  logic                      div_done_i,
   input  logic                      int_req_i,
   input  logic [CPU_WIDTH-1:0]      int_addr_i,
   output logic [FLOW_WIDTH-1:0]     flow_pc_o,
   output logic [FLOW_WIDTH-1:0]     flow_if_id_o,
   output logic [FLOW_WIDTH-1:0]     flow_id_ex_o,
   output logic [FLOW_WIDTH-1:0]     flow_ex_mem_o,
   output logic                      pc_jump_en_o,
   output logic [CPU_WIDTH-1:0]      pc_jump_addr_o,
   output logic                      int_ack_o,
   output logic                      div_err_o
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DIV_WAIT  = 2'd1,
      INT_DRAIN = 2'd2,
      INT_JUMP  = 2'd3
   } state_t;

   localparam logic [6:0] DIV_LAST = 7'(DIV_TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [6:0]             div_cnt;
   logic [CPU_WIDTH-1:0]   int_addr_q;
   logic                   load_use;
   logic                   div_clr, int_cap, ack_set, err_set;

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   always_comb begin
      load_use = ex_mem_rd_i && (ex_rd_adder_i != '0) &&
                 ((id_rs1_use_i && (id_rs1_adder_i == ex_rd_adder_i)) ||
                  (id_rs2_use_i && (id_rs2_adder_i == ex_rd_adder_i)));
   end

   always_comb begin
      state_d        = state_q;
      flow_pc_o      = FLOW_WORK;
      flow_if_id_o   = FLOW_WORK;
      flow_id_ex_o   = FLOW_WORK;
      flow_ex_mem_o  = FLOW_WORK;
      pc_jump_en_o   = 1'b0;
      pc_jump_addr_o = '0;
      div_clr        = 1'b0;
      int_cap        = 1'b0;
      ack_set        = 1'b0;
      err_set        = 1'b0;

      case (state_q)
         RUN: begin
            if (ex_jump_i) begin
               pc_jump_en_o   = 1'b1;
               pc_jump_addr_o = ex_jump_addr_i;
               flow_if_id_o   = FLOW_REFRESH;
               flow_id_ex_o   = FLOW_REFRESH;
            end else if (div_start_i) begin
               flow_pc_o     = FLOW_STOP;
               flow_if_id_o  = FLOW_STOP;
               flow_id_ex_o  = FLOW_STOP;
               flow_ex_mem_o = FLOW_REFRESH;
               div_clr       = 1'b1;
               state_d       = DIV_WAIT;
            end else if (int_req_i) begin
               // The instruction already in EX is allowed to retire.
               flow_pc_o    = FLOW_STOP;
               flow_if_id_o = FLOW_REFRESH;
               flow_id_ex_o = FLOW_REFRESH;
               int_cap      = 1'b1;
               state_d      = INT_DRAIN;
            end else if (load_use) begin
               flow_pc_o    = FLOW_STOP;
               flow_if_id_o = FLOW_STOP;
               flow_id_ex_o = FLOW_REFRESH;
            end
         end

         DIV_WAIT: begin
            if (div_done_i) begin
               state_d = RUN;
            end else if (div_cnt == DIV_LAST) begin
               err_set = 1'b1;
               state_d = RUN;
            end else begin
               flow_pc_o     = FLOW_STOP;
               flow_if_id_o  = FLOW_STOP;
               flow_id_ex_o  = FLOW_STOP;
               flow_ex_mem_o = FLOW_REFRESH;
            end
         end

         INT_DRAIN: begin
            flow_pc_o     = FLOW_STOP;
            flow_if_id_o  = FLOW_REFRESH;
            flow_id_ex_o  = FLOW_REFRESH;
            flow_ex_mem_o = FLOW_REFRESH;
            state_d       = INT_JUMP;
         end

         INT_JUMP: begin
            pc_jump_en_o   = 1'b1;
            pc_jump_addr_o = int_addr_q;
            flow_if_id_o   = FLOW_REFRESH;
            flow_id_ex_o   = FLOW_REFRESH;
            ack_set        = 1'b1;
            state_d        = RUN;
         end

         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         div_cnt    <= '0;
         int_addr_q <= '0;
         int_ack_o  <= 1'b0;
         div_err_o  <= 1'b0;
      end else begin
         state_q   <= state_d;
         int_ack_o <= ack_set;
         div_err_o <= err_set;
         if (div_clr)
            div_cnt <= '0;
         else if (state_q == DIV_WAIT)
            div_cnt <= div_cnt + 7'd1;
         if (int_cap)
            int_addr_q <= int_addr_i;
      end
   end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl. Expected per-cycle outputs are
// queued as stimulus is driven; a negedge monitor queues observed outputs;
// each scenario task then drains both queues and compares.
module tb_pipe_flow_ctrl;

   localparam logic [1:0] W = 2'b00;
   localparam logic [1:0] S = 2'b01;
   localparam logic [1:0] R = 2'b10;

   typedef struct packed {
      logic [1:0]  pc;
      logic [1:0]  ifid;
      logic [1:0]  idex;
      logic [1:0]  exmem;
      logic        jen;
      logic [31:0] jaddr;
      logic        ack;
      logic        err;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_jump_i = 1'b0;
   logic [31:0] ex_jump_addr_i = '0;
   logic        ex_mem_rd_i = 1'b0;
   logic [4:0]  ex_rd_adder_i = '0;
   logic [4:0]  id_rs1_adder_i = '0;
   logic        id_rs1_use_i = 1'b0;
   logic [4:0]  id_rs2_adder_i = '0;
   logic        id_rs2_use_i = 1'b0;
   logic        div_start_i = 1'b0;
   logic        div_done_i = 1'b0;
   logic        int_req_i = 1'b0;
   logic [31:0] int_addr_i = '0;
   logic [1:0]  flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o;
   logic        pc_jump_en_o;
   logic [31:0] pc_jump_addr_o;
   logic        int_ack_o, div_err_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic        mon_en   = 1'b0;
   obs_t        exp_q[$];
   obs_t        obs_q[$];

   pipe_flow_ctrl #(
      .FLOW_WIDTH(2), .CPU_WIDTH(32), .REG_ADDR_WIDTH(5), .DIV_TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst),
      .ex_jump_i(ex_jump_i), .ex_jump_addr_i(ex_jump_addr_i),
      .ex_mem_rd_i(ex_mem_rd_i), .ex_rd_adder_i(ex_rd_adder_i),
      .id_rs1_adder_i(id_rs1_adder_i), .id_rs1_use_i(id_rs1_use_i),
      .id_rs2_adder_i(id_rs2_adder_i), .id_rs2_use_i(id_rs2_use_i),
      .div_start_i(div_start_i), .div_done_i(div_done_i),
      .int_req_i(int_req_i), .int_addr_i(int_addr_i),
      .flow_pc_o(flow_pc_o), .flow_if_id_o(flow_if_id_o),
      .flow_id_ex_o(flow_id_ex_o), .flow_ex_mem_o(flow_ex_mem_o),
      .pc_jump_en_o(pc_jump_en_o), .pc_jump_addr_o(pc_jump_addr_o),
      .int_ack_o(int_ack_o), .div_err_o(div_err_o)
   );

   always #5 clk = ~clk;

   // Redirect address is only meaningful while pc_jump_en_o is high.
   always @(negedge clk) begin : monitor
      obs_t o;
      if (mon_en) begin
         o.pc    = flow_pc_o;
         o.ifid  = flow_if_id_o;
         o.idex  = flow_id_ex_o;
         o.exmem = flow_ex_mem_o;
         o.jen   = pc_jump_en_o;
         o.jaddr = pc_jump_en_o ? pc_jump_addr_o : 32'h0;
         o.ack   = int_ack_o;
         o.err   = div_err_o;
         obs_q.push_back(o);
      end
   end

   function automatic obs_t mk(input logic [1:0] pc, input logic [1:0] ifid,
                               input logic [1:0] idex, input logic [1:0] exmem,
                               input logic jen, input logic [31:0] ja,
                               input logic ack, input logic err);
      obs_t e;
      e.pc = pc; e.ifid = ifid; e.idex = idex; e.exmem = exmem;
      e.jen = jen; e.jaddr = ja; e.ack = ack; e.err = err;
      return e;
   endfunction

   function automatic string fmt(input obs_t v);
      return $sformatf("pc=%b ifid=%b idex=%b exmem=%b jen=%b addr=%h ack=%b err=%b",
                       v.pc, v.ifid, v.idex, v.exmem, v.jen, v.jaddr, v.ack, v.err);
   endfunction

   // Queue the expectation for the current cycle and advance one clock.
   task automatic step(input obs_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic begin_scenario();
      exp_q.delete();
      obs_q.delete();
      mon_en = 1'b1;
   endtask

   task automatic test_reset();
      obs_t e, o;
      int unsigned i;
      @(posedge clk); #1;
      begin_scenario();
      step(mk(W, W, W, W, 0, 0, 0, 0));
      rst = 1'b0;
      step(mk(W, W, W, W, 0, 0, 0, 0));
      step(mk(W, W, W, W, 0, 0, 0, 0));
      mon_en = 1'b0;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL reset[%0d]: no sample, required %s", i, fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++; $display("FAIL reset[%0d]: got %s required %s", i, fmt(o), fmt(e));
            end
         end
         i++;
      end
   endtask

   task automatic test_jump();
      obs_t e, o;
      int unsigned i;
      begin_scenario();
      ex_jump_i = 1'b1; ex_jump_addr_i = 32'h0000_0100;
      step(mk(W, R, R, W, 1, 32'h100, 0, 0));
      ex_jump_i = 1'b0; ex_jump_addr_i = '0;
      step(mk(W, W, W, W, 0, 0, 0, 0));
      // jump beats a simultaneous divide start
      ex_jump_i = 1'b1; ex_jump_addr_i = 32'h0000_0200; div_start_i = 1'b1;
      step(mk(W, R, R, W, 1, 32'h200, 0, 0));
      ex_jump_i = 1'b0; div_start_i = 1'b0;
      step(mk(W, W, W, W, 0, 0, 0, 0));
      mon_en = 1'b0;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL jump[%0d]: no sample, required %s", i, fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++; $display("FAIL jump[%0d]: got %s required %s", i, fmt(o), fmt(e));
            end
         end
         i++;
      end
   endtask

   typedef struct packed {
      logic       mem_rd;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic       use1;
      logic [4:0] rs2;
      logic       use2;
      logic       stall;
   } lu_t;

   task automatic test_load_use();
      obs_t e, o;
      int unsigned i;
      lu_t tbl[6];
      tbl[0] = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1};
      tbl[1] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 5'd9, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0};
      begin_scenario();
      for (int k = 0; k < 6; k++) begin
         ex_mem_rd_i = tbl[k].mem_rd; ex_rd_adder_i = tbl[k].rd;
         id_rs1_adder_i = tbl[k].rs1; id_rs1_use_i = tbl[k].use1;
         id_rs2_adder_i = tbl[k].rs2; id_rs2_use_i = tbl[k].use2;
         if (tbl[k].stall) step(mk(S, S, R, W, 0, 0, 0, 0));
         else              step(mk(W, W, W, W, 0, 0, 0, 0));
         ex_mem_rd_i = 1'b0; id_rs1_use_i = 1'b0; id_rs2_use_i = 1'b0;
         step(mk(W, W, W, W, 0, 0, 0, 0));
      end
      mon_en = 1'b0;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL load_use[%0d]: no sample, required %s", i, fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++; $display("FAIL load_use[%0d]: got %s required %s", i, fmt(o), fmt(e));
            end
         end
         i++;
      end
   endtask

   task automatic test_div_done();
      obs_t e, o;
      int unsigned i;
      begin_scenario();
      // div_done in RUN has no effect
      div_done_i = 1'b1;
      step(mk(W, W, W, W, 0, 0, 0, 0));
      div_done_i = 1'b0;
      div_start_i = 1'b1;
      step(mk(S, S, S, R, 0, 0, 0, 0));
      div_start_i = 1'b0;
      for (int k = 1; k < 10; k++) begin
         // jump is ignored while waiting on the divider
         ex_jump_i = (k == 4); ex_jump_addr_i = 32'h0000_0440;
         step(mk(S, S, S, R, 0, 0, 0, 0));
      end
      ex_jump_i = 1'b0;
      div_done_i = 1'b1;
      step(mk(W, W, W, W, 0, 0, 0, 0));
      div_done_i = 1'b0;
      step(mk(W, W, W, W, 0, 0, 0, 0));
      step(mk(W, W, W, W, 0, 0, 0, 0));
      mon_en = 1'b0;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL div_done[%0d]: no sample, required %s", i, fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++; $display("FAIL div_done[%0d]: got %s required %s", i, fmt(o), fmt(e));
            end
         end
         i++;
      end
   endtask

   task automatic test_div_timeout();
      obs_t e, o;
      int unsigned i;
      begin_scenario();
      div_start_i = 1'b1;
      step(mk(S, S, S, R, 0, 0, 0, 0));
      div_start_i = 1'b0;
      for (int k = 1; k < 64; k++)
         step(mk(S, S, S, R, 0, 0, 0, 0));
      step(mk(W, W, W, W, 0, 0, 0, 0));
      step(mk(W, W, W, W, 0, 0, 0, 1));
      step(mk(W, W, W, W, 0, 0, 0, 0));
      mon_en = 1'b0;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL div_timeout[%0d]: no sample, required %s", i, fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++; $display("FAIL div_timeout[%0d]: got %s required %s", i, fmt(o), fmt(e));
            end
         end
         i++;
      end
   endtask

   task automatic test_interrupt();
      obs_t e, o;
      int unsigned i;
      begin_scenario();
      int_req_i = 1'b1; int_addr_i = 32'h8000_0004;
      step(mk(S, R, R, W, 0, 0, 0, 0));
      // vector is latched at acceptance; later changes must not leak through
      int_req_i = 1'b0; int_addr_i = 32'hDEAD_BEEF;
      step(mk(S, R, R, R, 0, 0, 0, 0));
      step(mk(W, R, R, W, 1, 32'h8000_0004, 0, 0));
      step(mk(W, W, W, W, 0, 0, 1, 0));
      step(mk(W, W, W, W, 0, 0, 0, 0));
      mon_en = 1'b0;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL interrupt[%0d]: no sample, required %s", i, fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++; $display("FAIL interrupt[%0d]: got %s required %s", i, fmt(o), fmt(e));
            end
         end
         i++;
      end
   endtask

   task automatic test_jump_int();
      obs_t e, o;
      int unsigned i;
      begin_scenario();
      ex_jump_i = 1'b1; ex_jump_addr_i = 32'h0000_0300;
      int_req_i = 1'b1; int_addr_i = 32'h0000_0040;
      step(mk(W, R, R, W, 1, 32'h300, 0, 0));
      ex_jump_i = 1'b0;
      step(mk(S, R, R, W, 0, 0, 0, 0));
      int_req_i = 1'b0;
      step(mk(S, R, R, R, 0, 0, 0, 0));
      step(mk(W, R, R, W, 1, 32'h40, 0, 0));
      step(mk(W, W, W, W, 0, 0, 1, 0));
      step(mk(W, W, W, W, 0, 0, 0, 0));
      mon_en = 1'b0;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL jump_int[%0d]: no sample, required %s", i, fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++; $display("FAIL jump_int[%0d]: got %s required %s", i, fmt(o), fmt(e));
            end
         end
         i++;
      end
   endtask

   task automatic test_reset_div();
      obs_t e, o;
      int unsigned i;
      begin_scenario();
      div_start_i = 1'b1;
      step(mk(S, S, S, R, 0, 0, 0, 0));
      div_start_i = 1'b0;
      for (int k = 0; k < 3; k++)
         step(mk(S, S, S, R, 0, 0, 0, 0));
      rst = 1'b1;
      step(mk(W, W, W, W, 0, 0, 0, 0));
      rst = 1'b0;
      for (int k = 0; k < 70; k++)
         step(mk(W, W, W, W, 0, 0, 0, 0));
      mon_en = 1'b0;
      i = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL reset_div[%0d]: no sample, required %s", i, fmt(e));
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++; $display("FAIL reset_div[%0d]: got %s required %s", i, fmt(o), fmt(e));
            end
         end
         i++;
      end
   endtask

   initial begin
      test_reset();
      test_jump();
      test_load_use();
      test_div_done();
      test_div_timeout();
      test_interrupt();
      test_jump_int();
      test_reset_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

endmodule
